// File: rtl/modexp_if.sv
// Strobe/status bundle between the modexp sequencing controller
// and its arithmetic datapath.
interface modexp_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
);
    logic [WIDTH-1:0] data_in;
    logic             update_e;
    logic             update_n;
    logic             initialize;
    logic             en_multiply;
    logic             en_modulo;
    logic             done;
    logic             is_init_done;
    logic             is_multiplication_done;
    logic [WIDTH-1:0] result;
    logic             result_valid;
    logic [CNT_W-1:0] mult_count;
    logic             protocol_err;

    modport master (
        output data_in, update_e, update_n, initialize,
        output en_multiply, en_modulo, done,
        input  is_init_done, is_multiplication_done,
        input  result, result_valid, mult_count, protocol_err
    );

    modport slave (
        input  data_in, update_e, update_n, initialize,
        input  en_multiply, en_modulo, done,
        output is_init_done, is_multiplication_done,
        output result, result_valid, mult_count, protocol_err
    );
endinterface

// File: rtl/modexp_datapath.sv
// RSA modexp datapath: right-to-left square-and-multiply,
// one exponent bit per multiply/modulo strobe pair.
module modexp_datapath #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input logic     clk,
    input logic     rst_n,
    modexp_if.slave bus
);
    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READY   = 2'd1,
        PRODUCT = 2'd2
    } phase_t;

    phase_t           phase;
    phase_t           phase_nxt;
    logic [WIDTH-1:0] e_reg;
    logic [WIDTH-1:0] n_reg;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] exp;
    logic [PW-1:0]    prod_acc;
    logic [PW-1:0]    prod_base;
    logic [PW-1:0]    acc_x;
    logic [PW-1:0]    base_x;
    logic             upd;
    logic             multi;
    logic             do_load;
    logic             do_init;
    logic             do_mul;
    logic             do_mod;
    logic             do_done;
    logic             bad;

    // Reduction by zero is defined as 0 rather than X.
    function automatic logic [WIDTH-1:0] red(
        input logic [PW-1:0]    a,
        input logic [WIDTH-1:0] m
    );
        logic [PW-1:0] q;
        q = '0;
        if (m != '0)
            q = a % {{WIDTH{1'b0}}, m};
        return q[WIDTH-1:0];
    endfunction

    assign acc_x  = {{WIDTH{1'b0}}, acc};
    assign base_x = {{WIDTH{1'b0}}, base};
    assign upd    = bus.update_e | bus.update_n;

    always_comb begin
        multi = $countones({upd, bus.initialize, bus.en_multiply,
                            bus.en_modulo, bus.done}) > 1;
        do_load = upd && phase == IDLE && !multi;
        do_init = bus.initialize && phase == IDLE && !multi;
        do_mul  = bus.en_multiply && phase == READY
                  && exp != '0 && !multi;
        do_mod  = bus.en_modulo && phase == PRODUCT && !multi;
        do_done = bus.done && phase == READY && !multi;
        bad = multi
            | (upd && phase != IDLE)
            | (bus.en_multiply && !(phase == READY && exp != '0))
            | (bus.en_modulo && phase != PRODUCT)
            | (bus.done && phase != READY)
            | (do_init && n_reg == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            phase <= IDLE;
        else
            phase <= phase_nxt;
    end

    always_comb begin
        phase_nxt = phase;
        unique case (phase)
            IDLE:    if (do_init) phase_nxt = READY;
            READY: begin
                if (do_mul)
                    phase_nxt = PRODUCT;
                else if (do_done)
                    phase_nxt = IDLE;
            end
            PRODUCT: if (do_mod) phase_nxt = READY;
            default: phase_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            e_reg            <= '0;
            n_reg            <= '0;
            base             <= '0;
            acc              <= '0;
            exp              <= '0;
            prod_acc         <= '0;
            prod_base        <= '0;
            bus.mult_count   <= '0;
            bus.result       <= '0;
            bus.result_valid <= 1'b0;
            bus.is_init_done <= 1'b0;
            bus.protocol_err <= 1'b0;
        end else begin
            if (bad)
                bus.protocol_err <= 1'b1;
            if (!bus.initialize)
                bus.is_init_done <= 1'b0;
            if (do_load) begin
                if (bus.update_e) e_reg <= bus.data_in;
                if (bus.update_n) n_reg <= bus.data_in;
            end
            if (do_init) begin
                base             <= red({{WIDTH{1'b0}}, bus.data_in}, n_reg);
                acc              <= red({{(PW-1){1'b0}}, 1'b1}, n_reg);
                exp              <= e_reg;
                bus.mult_count   <= '0;
                bus.result_valid <= 1'b0;
                bus.is_init_done <= 1'b1;
            end
            if (do_mul) begin
                prod_acc  <= exp[0] ? acc_x * base_x : acc_x;
                prod_base <= base_x * base_x;
            end
            if (do_mod) begin
                acc            <= red(prod_acc, n_reg);
                base           <= red(prod_base, n_reg);
                exp            <= exp >> 1;
                bus.mult_count <= bus.mult_count + CNT_W'(1);
            end
            if (do_done) begin
                bus.result       <= acc;
                bus.result_valid <= 1'b1;
            end
        end
    end

    assign bus.is_multiplication_done = (phase == READY) && (exp == '0);
endmodule

// File: tb/tb_modexp_datapath.sv
// Directed bench for modexp_datapath with a plain-arithmetic
// modular-exponentiation model and a per-cycle compare process.
module tb_modexp_datapath;
    localparam int W = 32;
    localparam int C = 6;

    logic clk;
    logic rst_n;
    modexp_if #(.WIDTH(W), .CNT_W(C)) bus ();
    modexp_datapath #(.WIDTH(W), .CNT_W(C)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int total = 0;
    int bad = 0;
    bit chk_on = 0;

    logic [W-1:0] m_e;
    logic [W-1:0] m_n;
    logic [W-1:0] m_result;
    logic         m_valid;
    logic         m_err;
    int           m_cnt;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic longint unsigned modpow(
        input longint unsigned b,
        input longint unsigned e,
        input longint unsigned n
    );
        longint unsigned r;
        if (n == 0) return 0;
        r = 1 % n;
        b = b % n;
        while (e != 0) begin
            if (e[0]) r = (r * b) % n;
            b = (b * b) % n;
            e = e >> 1;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t",
                     name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("protocol_err", 64'(bus.protocol_err), 64'(m_err));
            chk("result_valid", 64'(bus.result_valid), 64'(m_valid));
            if (m_valid)
                chk("result", 64'(bus.result), 64'(m_result));
            chk("mult_count", 64'(bus.mult_count), 64'(m_cnt));
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset;
        m_e = '0; m_n = '0; m_result = '0;
        m_valid = 0; m_err = 0; m_cnt = 0;
    endtask

    task automatic do_reset;
        rst_n = 0;
        step;
        model_reset;
        rst_n = 1;
    endtask

    task automatic load(input logic [W-1:0] e, input logic [W-1:0] n,
                        input bit le, input bit ln);
        bus.update_e = le;
        bus.update_n = ln;
        bus.data_in  = le ? e : n;
        if (le && ln) begin
            // both coincide: give each its own value in successive cycles
            bus.update_n = 0;
            step;
            bus.update_e = 0;
            bus.update_n = 1;
            bus.data_in  = n;
        end
        step;
        bus.update_e = 0;
        bus.update_n = 0;
        if (le) m_e = e;
        if (ln) m_n = n;
    endtask

    task automatic run(input logic [W-1:0] msg, input bit inject);
        logic [63:0] ref_v;
        int k;
        ref_v = 64'(modpow(64'(msg), 64'(m_e), 64'(m_n)));
        k = 0;
        for (int i = 0; i < W; i++) if (m_e[i]) k = i + 1;
        bus.data_in = msg;
        bus.initialize = 1;
        step;
        m_valid = 0;
        m_cnt = 0;
        if (m_n == 0) m_err = 1;
        chk("init_done_1", 64'(bus.is_init_done), 1);
        step;
        chk("init_done_2", 64'(bus.is_init_done), 1);
        bus.initialize = 0;
        for (int i = 0; i < k; i++) begin
            chk("mul_done_lo", 64'(bus.is_multiplication_done), 0);
            bus.en_multiply = 1;
            step;
            bus.en_multiply = 0;
            if (inject && i == 1) begin
                bus.update_e = 1;
                bus.data_in = 999;
                step;
                bus.update_e = 0;
                bus.data_in = msg;
                m_err = 1;
            end
            bus.en_modulo = 1;
            step;
            bus.en_modulo = 0;
            m_cnt++;
            if (inject && i == 0) begin
                bus.en_modulo = 1;
                step;
                bus.en_modulo = 0;
                m_err = 1;
            end
        end
        chk("mul_done_hi", 64'(bus.is_multiplication_done), 1);
        step;
        chk("init_done_clr", 64'(bus.is_init_done), 0);
        bus.done = 1;
        step;
        bus.done = 0;
        m_valid = 1;
        m_result = ref_v[W-1:0];
        step;
    endtask

    initial begin
        rst_n = 0;
        bus.data_in = '0;
        bus.update_e = 0;
        bus.update_n = 0;
        bus.initialize = 0;
        bus.en_multiply = 0;
        bus.en_modulo = 0;
        bus.done = 0;
        model_reset;
        step;
        chk_on = 1;
        step;
        chk("rst_result", 64'(bus.result), 0);
        chk("rst_init_done", 64'(bus.is_init_done), 0);
        chk("rst_mul_done", 64'(bus.is_multiplication_done), 0);
        rst_n = 1;

        chk("model_a", modpow(65, 17, 3233), 2790);
        chk("model_b", modpow(2790, 2753, 3233), 65);
        chk("model_c", modpow(1234, 0, 3233), 1);
        chk("model_d", modpow(7, 5, 0), 0);

        load(17, 3233, 1, 1);
        run(65, 0);
        chk("t1_result", 64'(bus.result), 2790);
        chk("t1_count", 64'(bus.mult_count), 5);

        load(2753, 0, 1, 0);
        run(2790, 0);
        chk("t2_result", 64'(bus.result), 65);
        chk("t2_count", 64'(bus.mult_count), 12);

        load(0, 3233, 1, 1);
        run(1234, 0);
        chk("t3_result", 64'(bus.result), 1);
        chk("t3_count", 64'(bus.mult_count), 0);
        load(0, 1, 0, 1);
        run(1234, 0);
        chk("t3_n1_result", 64'(bus.result), 0);

        load(5, 0, 1, 1);
        run(7, 0);
        chk("t4_err", 64'(bus.protocol_err), 1);
        chk("t4_result", 64'(bus.result), 0);
        do_reset;
        chk("t4_rst_err", 64'(bus.protocol_err), 0);
        chk("t4_rst_result", 64'(bus.result), 0);
        chk("t4_rst_valid", 64'(bus.result_valid), 0);

        load(17, 3233, 1, 1);
        run(65, 1);
        chk("t5_result", 64'(bus.result), 2790);
        chk("t5_err", 64'(bus.protocol_err), 1);
        run(65, 0);
        chk("t5_rerun", 64'(bus.result), 2790);
        do_reset;

        load(17, 3233, 1, 1);
        bus.data_in = 65;
        bus.initialize = 1;
        step;
        m_valid = 0;
        m_cnt = 0;
        step;
        bus.initialize = 0;
        bus.en_multiply = 1;
        step;
        bus.en_multiply = 0;
        do_reset;
        chk("t6_phase_idle", 64'(bus.is_multiplication_done), 0);
        chk("t6_valid", 64'(bus.result_valid), 0);
        run(5, 0);
        chk("t6_n_cleared", 64'(bus.protocol_err), 1);
        do_reset;
        load(17, 3233, 1, 1);
        run(65, 0);
        chk("t6_result", 64'(bus.result), 2790);

        chk_on = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
